mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_stage                                                     |
// | Description : Pipeline MEM stage; single-outstanding bus master with        |
// |               load/store lane steering and misalign/bus fault reporting.    |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+

package mem_stage_pkg;
  typedef enum logic [3:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LB   = 4'd1,
    MEM_OP_LBU  = 4'd2,
    MEM_OP_LH   = 4'd3,
    MEM_OP_LHU  = 4'd4,
    MEM_OP_LW   = 4'd5,
    MEM_OP_SB   = 4'd6,
    MEM_OP_SH   = 4'd7,
    MEM_OP_SW   = 4'd8
  } mem_op_t;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    mem_op_t     mem_op;
    logic [31:0] mem_data;
  } mem_params_t;
endpackage

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  mem_params_t mem_params,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_rd_data,
  output logic        fault_misalign,
  output logic        fault_bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_stall;
  logic        w_done;
  logic        w_issue;

  mem_op_t     w_op;
  logic [31:0] w_addr;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_mem;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  mem_op_t     r_op;
  logic [1:0]  r_lo;
  logic [4:0]  r_rd_addr;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_op     = mem_params.mem_op;
  assign w_addr   = mem_params.rd_data;
  assign w_is_mem = w_is_load | w_is_store;

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_misalign = 1'b0;
    w_be       = 4'b0000;
    w_wdata    = 32'h0;
    case (w_op)
      MEM_OP_LB, MEM_OP_LBU: w_is_load = 1'b1;
      MEM_OP_LH, MEM_OP_LHU: begin
        w_is_load  = 1'b1;
        w_misalign = w_addr[0];
      end
      MEM_OP_LW: begin
        w_is_load  = 1'b1;
        w_misalign = |w_addr[1:0];
      end
      MEM_OP_SB: begin
        w_is_store = 1'b1;
        w_wdata    = {4{mem_params.mem_data[7:0]}};
        w_be       = 4'b0001 << w_addr[1:0];
      end
      MEM_OP_SH: begin
        w_is_store = 1'b1;
        w_misalign = w_addr[0];
        w_wdata    = {2{mem_params.mem_data[15:0]}};
        w_be       = w_addr[1] ? 4'b1100 : 4'b0011;
      end
      MEM_OP_SW: begin
        w_is_store = 1'b1;
        w_misalign = |w_addr[1:0];
        w_wdata    = mem_params.mem_data;
        w_be       = 4'b1111;
      end
      default: ;
    endcase
  end

  // Load lanes use the op and offset captured at issue, not the live inputs.
  assign w_byte = bus_rdata[{r_lo, 3'b000} +: 8];
  assign w_half = r_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    w_load_data = bus_rdata;
    case (r_op)
      MEM_OP_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
      MEM_OP_LBU: w_load_data = {24'h0, w_byte};
      MEM_OP_LH:  w_load_data = {{16{w_half[15]}}, w_half};
      MEM_OP_LHU: w_load_data = {16'h0, w_half};
      default:    w_load_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_issue      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (valid_in && w_is_mem && !w_misalign) begin
          w_stall      = 1'b1;
          w_issue      = 1'b1;
          w_state_next = ST_BUS;
        end
      end
      ST_BUS: begin
        if (bus_ack || bus_err) begin
          w_done       = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign stall = w_stall & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req        <= 1'b0;
      bus_we         <= 1'b0;
      bus_be         <= 4'b0000;
      bus_addr       <= 32'h0;
      bus_wdata      <= 32'h0;
      wb_valid       <= 1'b0;
      wb_we          <= 1'b0;
      wb_rd_addr     <= 5'd0;
      wb_rd_data     <= 32'h0;
      fault_misalign <= 1'b0;
      fault_bus      <= 1'b0;
      r_op           <= MEM_OP_NONE;
      r_lo           <= 2'b00;
      r_rd_addr      <= 5'd0;
    end else begin
      wb_valid       <= 1'b0;
      fault_misalign <= 1'b0;
      fault_bus      <= 1'b0;
      if (r_state == ST_IDLE && valid_in) begin
        if (!w_is_mem) begin
          wb_valid   <= 1'b1;
          wb_we      <= |mem_params.rd_addr;
          wb_rd_addr <= mem_params.rd_addr;
          wb_rd_data <= mem_params.rd_data;
        end else if (w_misalign) begin
          wb_valid       <= 1'b1;
          wb_we          <= 1'b0;
          wb_rd_addr     <= mem_params.rd_addr;
          wb_rd_data     <= 32'h0;
          fault_misalign <= 1'b1;
        end else if (w_issue) begin
          bus_req   <= 1'b1;
          bus_we    <= w_is_store;
          bus_be    <= w_be;
          bus_addr  <= {w_addr[31:2], 2'b00};
          bus_wdata <= w_wdata;
          r_op      <= w_op;
          r_lo      <= w_addr[1:0];
          r_rd_addr <= mem_params.rd_addr;
        end
      end else if (w_done) begin
        bus_req    <= 1'b0;
        wb_valid   <= 1'b1;
        wb_rd_addr <= r_rd_addr;
        if (bus_err) begin
          wb_we      <= 1'b0;
          wb_rd_data <= 32'h0;
          fault_bus  <= 1'b1;
        end else if (bus_we) begin
          wb_we      <= 1'b0;
          wb_rd_data <= 32'h0;
        end else begin
          wb_we      <= |r_rd_addr;
          wb_rd_data <= w_load_data;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_stage                                                  |
// | Description : Scoreboard bench for mem_stage with a behavioural model.     |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  mem_params_t mem_params = '0;
  logic        stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0, bus_err = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;
  logic        fault_misalign, fault_bus;

  mem_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_params(mem_params),
    .stall(stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack), .bus_err(bus_err),
    .bus_rdata(bus_rdata), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .fault_misalign(fault_misalign), .fault_bus(fault_bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        fm;
    logic        fb;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: access size, sign, lanes from plain arithmetic.
  function automatic int op_size(input mem_op_t op);
    case (op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: return 1;
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return 2;
      MEM_OP_LW, MEM_OP_SW:             return 4;
      default:                          return 0;
    endcase
  endfunction

  function automatic bit op_store(input mem_op_t op);
    return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
  endfunction

  function automatic logic [31:0] load_val(input mem_op_t op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int     sz;
    int     off;
    longint v;
    longint m;
    sz  = op_size(op);
    off = int'(addr % 4);
    if (sz == 4) return rdata;
    v = longint'(rdata) >> (8 * off);
    m = longint'(1) << (8 * sz);
    v = v % m;
    if ((op == MEM_OP_LB || op == MEM_OP_LH) && v >= m / 2) v = v - m;
    return v[31:0];
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a writeback.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL wb_missing: got none expected wb at cycle %0d", q[0].cyc);
      void'(q.pop_front());
    end
    if (wb_valid) begin
      if (q.size() == 0 || q[0].cyc != cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d data=%h expected none (cycle %0d)",
                 wb_rd_addr, wb_rd_data, cyc);
      end else begin
        e = q.pop_front();
        check("wb_result", {24'h0, wb_we, wb_rd_addr, wb_rd_data, fault_misalign, fault_bus},
              {24'h0, e.we, e.rd, e.data, e.fm, e.fb});
      end
    end else begin
      check("fault_without_valid", {62'h0, fault_misalign, fault_bus}, 64'h0);
    end
  end

  task automatic issue(input mem_op_t op, input logic [4:0] rd, input logic [31:0] addr,
                       input logic [31:0] data, input int waits, input bit err,
                       input bit ack_too, input logic [31:0] rdata, input bit scramble);
    exp_t        e;
    int          sz;
    bit          mis;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    sz  = op_size(op);
    mis = (sz > 1) && ((addr % sz) != 0);
    valid_in = 1'b1;
    mem_params = '{rd, addr, op, data};
    e.rd = rd; e.fm = 1'b0; e.fb = 1'b0;
    if (sz == 0) begin
      e.cyc = cyc + 1; e.we = (rd != 0); e.data = addr;
      q.push_back(e);
      #1 check("stall_none", {63'h0, stall}, 64'h0);
      @(posedge clk); #1;
    end else if (mis) begin
      e.cyc = cyc + 1; e.we = 1'b0; e.data = 32'h0; e.fm = 1'b1;
      q.push_back(e);
      #1 check("stall_misalign", {63'h0, stall}, 64'h0);
      @(posedge clk); #1;
      check("no_bus_misalign", {63'h0, bus_req}, 64'h0);
    end else begin
      e.cyc = cyc + 2 + waits;
      if (err) begin
        e.we = 1'b0; e.data = 32'h0; e.fb = 1'b1;
      end else if (op_store(op)) begin
        e.we = 1'b0; e.data = 32'h0;
      end else begin
        e.we = (rd != 0); e.data = load_val(op, addr, rdata);
      end
      q.push_back(e);
      ebe = 4'(((1 << sz) - 1) << (addr % 4));
      ewd = (sz == 1) ? data[7:0] * 32'h01010101 :
            (sz == 2) ? data[15:0] * 32'h00010001 : data;
      #1 check("stall_issue", {63'h0, stall}, 64'h1);
      @(posedge clk); #1;
      if (op_store(op))
        check("bus_store", {bus_req, bus_we, bus_be, bus_addr, bus_wdata[25:0]},
              {1'b1, 1'b1, ebe, addr & ~32'h3, ewd[25:0]});
      else
        check("bus_load", {26'h0, bus_req, bus_we, bus_be, bus_addr},
              {26'h0, 1'b1, 1'b0, 4'b0000 | (bus_be & 4'h0), addr & ~32'h3});
      if (op_store(op)) check("bus_wdata", {32'h0, bus_wdata}, {32'h0, ewd});
      if (scramble) begin
        mem_params.rd_addr  = 5'($urandom);
        mem_params.rd_data  = $urandom;
        mem_params.mem_data = $urandom;
      end
      for (int i = 0; i < waits; i++) begin
        check("stall_wait", {62'h0, stall, bus_req}, 64'h3);
        @(posedge clk); #1;
      end
      bus_err = err; bus_ack = !err || ack_too; bus_rdata = rdata;
      #1 check("stall_ack", {63'h0, stall}, 64'h0);
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
      check("bus_req_drop", {63'h0, bus_req}, 64'h0);
    end
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    mem_params = '{5'($urandom), $urandom, mem_op_t'($urandom_range(0, 8)), $urandom};
    bus_ack = 1'($urandom); bus_err = 1'($urandom);
    repeat (n) @(posedge clk);
    #1 bus_ack = 1'b0; bus_err = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check("reset_outputs", {bus_req, bus_we, bus_be, bus_addr, wb_valid, wb_we, wb_rd_addr,
                            fault_misalign, fault_bus, stall, 15'h0},
          64'h0);
    check("reset_data", {bus_wdata, wb_rd_data}, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    issue(MEM_OP_NONE, 5'd3, 32'h1234, 32'h0, 0, 0, 0, 0, 0);
    issue(MEM_OP_LB,  5'd5, 32'h103, 32'h0, 3, 0, 0, 32'h80FFFFFF, 1);
    issue(MEM_OP_LBU, 5'd6, 32'h103, 32'h0, 3, 0, 0, 32'h80FFFFFF, 0);
    issue(MEM_OP_SH,  5'd7, 32'h202, 32'hAAAABEEF, 1, 0, 0, 32'h0, 0);
    issue(MEM_OP_LW,  5'd8, 32'h105, 32'h0, 0, 0, 0, 32'h0, 0);
    issue(MEM_OP_LW,  5'd9, 32'h300, 32'h0, 2, 1, 1, 32'h12345678, 0);
    issue(MEM_OP_NONE, 5'd0, 32'hDEAD, 32'h0, 0, 0, 0, 0, 0);
    idle(2);

    // Reset in the middle of a bus cycle; a later stray ack must be ignored.
    valid_in = 1'b1;
    mem_params = '{5'd4, 32'h40, MEM_OP_LW, 32'h0};
    @(posedge clk); #1;
    valid_in = 1'b0;
    check("bus_req_before_rst", {63'h0, bus_req}, 64'h1);
    #2 rst = 1'b1;
    #1 check("rst_mid_bus", {bus_req, bus_we, bus_be, bus_addr, stall, wb_valid, 25'h0}, 64'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 bus_ack = 1'b1; bus_rdata = 32'hFFFF0000;
    @(posedge clk); #1 bus_ack = 1'b0;
    check("stray_ack_after_rst", {62'h0, bus_req, stall}, 64'h0);

    for (int n = 0; n < 300; n++) begin
      mem_op_t     op;
      logic [31:0] a;
      logic [4:0]  rd;
      op = mem_op_t'($urandom_range(0, 8));
      a  = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      issue(op, rd, a, $urandom, $urandom_range(0, 4), ($urandom_range(0, 7) == 0),
            1'($urandom), $urandom, 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    repeat (4) @(posedge clk);
    #1 check("scoreboard_drained", 64'(q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
